// File: rtl/pm_candidate_gen_if.sv
// LLR handshake and sorter bus of the SCL path-metric front end.
// The slave side is the candidate generator; the master side is the LLR source plus the sorter.
interface pm_candidate_gen_if #(
    parameter int PM_WIDTH  = 8,
    parameter int LLR_WIDTH = 6
);
    localparam int L = 4;

    logic                      llr_valid;
    logic                      llr_ready;
    logic [LLR_WIDTH*L-1:0]    llr_in;
    logic                      frozen;
    logic [PM_WIDTH*2*L-1:0]   cand_pm;
    logic                      cand_valid;
    logic [PM_WIDTH*L-1:0]     surv_pm;

    modport master (
        output llr_valid, llr_in, frozen, surv_pm,
        input  llr_ready, cand_pm, cand_valid
    );

    modport slave (
        input  llr_valid, llr_in, frozen, surv_pm,
        output llr_ready, cand_pm, cand_valid
    );
endinterface

// File: rtl/pm_candidate_gen.sv
// Writer side of the L=4 SCL path-metric sorter: expands PMs into 2L ordered candidates,
// captures the sorted survivors, and applies frozen-bit penalties without the sorter.
module pm_candidate_gen #(
    parameter int PM_WIDTH  = 8,
    parameter int LLR_WIDTH = 6,
    parameter int SORT_LAT  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    pm_candidate_gen_if.slave      sortBus,
    output logic [PM_WIDTH*4-1:0]  pm_out_o,
    output logic                   pm_valid_o,
    output logic [2:0]             path_cnt_o
);
    localparam int L     = 4;
    localparam int CNT_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SORT_LAT);

    typedef enum logic {IDLE, SORT} state_t;

    state_t                    stateQ;
    logic [CNT_W-1:0]          cntQ;
    logic [PM_WIDTH-1:0]       pmQ [L];
    logic [2:0]                pathCntQ;
    logic [PM_WIDTH*2*L-1:0]   candQ;
    logic                      candValidQ;
    logic                      pmValidQ;

    logic [PM_WIDTH-1:0]       frozenPmD [L];
    logic [PM_WIDTH*2*L-1:0]   candD;
    logic [2:0]                pathCntD;

    // Two's-complement magnitude fits LLR_WIDTH unsigned bits, so -2^(W-1) needs no extra bit.
    always_comb begin
        logic [LLR_WIDTH-1:0] llr;
        logic [LLR_WIDTH-1:0] absv;
        logic [PM_WIDTH-1:0]  mag;
        logic [PM_WIDTH:0]    wide;
        logic [PM_WIDTH-1:0]  sum;
        candD = '0;
        for (int l = 0; l < L; l++) begin
            llr  = sortBus.llr_in[LLR_WIDTH*(L-1-l) +: LLR_WIDTH];
            absv = llr[LLR_WIDTH-1] ? (~llr + LLR_WIDTH'(1)) : llr;
            mag  = PM_WIDTH'(absv);
            wide = {1'b0, pmQ[l]} + {1'b0, mag};
            sum  = wide[PM_WIDTH] ? '1 : wide[PM_WIDTH-1:0];
            frozenPmD[l] = llr[LLR_WIDTH-1] ? sum : pmQ[l];
            candD[PM_WIDTH*(2*L-1-2*l) +: PM_WIDTH] = pmQ[l];
            candD[PM_WIDTH*(2*L-2-2*l) +: PM_WIDTH] = sum;
        end
    end

    always_comb begin
        pathCntD = pathCntQ[2] ? 3'd4 : {pathCntQ[1:0], 1'b0};
        pm_out_o = '0;
        for (int l = 0; l < L; l++) begin
            pm_out_o[PM_WIDTH*(L-1-l) +: PM_WIDTH] = pmQ[l];
        end
    end

    assign sortBus.llr_ready  = (stateQ == IDLE) && !start_i;
    assign sortBus.cand_pm    = candQ;
    assign sortBus.cand_valid = candValidQ;
    assign pm_valid_o         = pmValidQ;
    assign path_cnt_o         = pathCntQ;

    // start overrides everything, including a SORT in flight whose survivors are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= IDLE;
            cntQ       <= '0;
            for (int l = 0; l < L; l++) pmQ[l] <= (l == 0) ? '0 : '1;
            pathCntQ   <= 3'd1;
            candQ      <= '0;
            candValidQ <= 1'b0;
            pmValidQ   <= 1'b0;
        end else begin
            pmValidQ <= 1'b0;
            if (start_i) begin
                stateQ     <= IDLE;
                cntQ       <= '0;
                for (int l = 0; l < L; l++) pmQ[l] <= (l == 0) ? '0 : '1;
                pathCntQ   <= 3'd1;
                candQ      <= '0;
                candValidQ <= 1'b0;
            end else begin
                case (stateQ)
                    IDLE: begin
                        if (sortBus.llr_valid) begin
                            if (sortBus.frozen) begin
                                for (int l = 0; l < L; l++) pmQ[l] <= frozenPmD[l];
                                pmValidQ <= 1'b1;
                            end else begin
                                candQ      <= candD;
                                candValidQ <= 1'b1;
                                cntQ       <= '0;
                                stateQ     <= SORT;
                            end
                        end
                    end
                    SORT: begin
                        if (cntQ == LAST_CNT) begin
                            for (int l = 0; l < L; l++) begin
                                pmQ[l] <= sortBus.surv_pm[PM_WIDTH*(L-1-l) +: PM_WIDTH];
                            end
                            pathCntQ   <= pathCntD;
                            candValidQ <= 1'b0;
                            pmValidQ   <= 1'b1;
                            stateQ     <= IDLE;
                        end else begin
                            cntQ <= cntQ + CNT_W'(1);
                        end
                    end
                    default: stateQ <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pm_candidate_gen.sv
// Scoreboard bench for pm_candidate_gen: one instance with a combinational sorter,
// one with a 3-cycle sorter that only presents valid survivors on its final cycle.
module tb_pm_candidate_gen;
    typedef struct {
        logic [31:0] pm;
        logic [2:0]  pc;
    } pmExp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] pmOut0, pmOut2;
    logic        pmValid0, pmValid2;
    logic [2:0]  pathCnt0, pathCnt2;
    int          sortCnt2 = 0;

    int          checks = 0;
    int          errors = 0;

    pmExp_t      expPm0[$];
    pmExp_t      expPm2[$];
    logic [63:0] expCand0[$];
    logic [63:0] expCand2[$];
    logic        prevCv[2] = '{1'b0, 1'b0};
    logic [63:0] heldCand[2];

    pm_candidate_gen_if #(.PM_WIDTH(8), .LLR_WIDTH(6)) bus0();
    pm_candidate_gen_if #(.PM_WIDTH(8), .LLR_WIDTH(6)) bus2();

    pm_candidate_gen #(.PM_WIDTH(8), .LLR_WIDTH(6), .SORT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .sortBus(bus0),
        .pm_out_o(pmOut0), .pm_valid_o(pmValid0), .path_cnt_o(pathCnt0)
    );

    pm_candidate_gen #(.PM_WIDTH(8), .LLR_WIDTH(6), .SORT_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .sortBus(bus2),
        .pm_out_o(pmOut2), .pm_valid_o(pmValid2), .path_cnt_o(pathCnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lowest4(logic [63:0] c);
        logic [7:0] v[8];
        logic [7:0] t;
        for (int i = 0; i < 8; i++) v[i] = c[63-8*i -: 8];
        for (int i = 1; i < 8; i++)
            for (int j = i; j > 0; j--)
                if (v[j] < v[j-1]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // The slow sorter drives junk until its last cycle, so an early capture is visible.
    assign bus0.surv_pm = lowest4(bus0.cand_pm);
    assign bus2.surv_pm = (sortCnt2 == 2) ? lowest4(bus2.cand_pm) : 32'h11111111;

    always @(posedge clk) begin
        if (bus2.cand_valid) sortCnt2 <= sortCnt2 + 1;
        else                 sortCnt2 <= 0;
    end

    task automatic checkOutput(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic getReady(int w);
        return (w == 0) ? bus0.llr_ready : bus2.llr_ready;
    endfunction

    function automatic logic getCv(int w);
        return (w == 0) ? bus0.cand_valid : bus2.cand_valid;
    endfunction

    function automatic logic getPv(int w);
        return (w == 0) ? pmValid0 : pmValid2;
    endfunction

    task automatic driveLlr(int w, logic v, logic [23:0] llr, logic frz);
        if (w == 0) begin
            bus0.llr_valid = v; bus0.llr_in = llr; bus0.frozen = frz;
        end else begin
            bus2.llr_valid = v; bus2.llr_in = llr; bus2.frozen = frz;
        end
    endtask

    task automatic pushExp(int w, logic frz, logic [63:0] cand, logic [31:0] pm, logic [2:0] pc);
        pmExp_t e;
        e.pm = pm;
        e.pc = pc;
        if (w == 0) begin
            if (!frz) expCand0.push_back(cand);
            expPm0.push_back(e);
        end else begin
            if (!frz) expCand2.push_back(cand);
            expPm2.push_back(e);
        end
    endtask

    task automatic monitorPm(int w, logic [31:0] act, logic [2:0] pc);
        pmExp_t e;
        int     n;
        n = (w == 0) ? expPm0.size() : expPm2.size();
        checkOutput($sformatf("pm_expected%0d", w), (n != 0), 1);
        if (n != 0) begin
            e = (w == 0) ? expPm0.pop_front() : expPm2.pop_front();
            checkOutput($sformatf("pm_out%0d", w), act, e.pm);
            checkOutput($sformatf("path_cnt%0d", w), pc, e.pc);
        end
    endtask

    task automatic monitorCand(int w, logic cv, logic [63:0] cand);
        int n;
        if (cv && !prevCv[w]) begin
            n = (w == 0) ? expCand0.size() : expCand2.size();
            checkOutput($sformatf("cand_expected%0d", w), (n != 0), 1);
            if (n != 0) begin
                heldCand[w] = (w == 0) ? expCand0.pop_front() : expCand2.pop_front();
                checkOutput($sformatf("cand_pm%0d", w), cand, heldCand[w]);
            end
        end else if (cv) begin
            checkOutput($sformatf("cand_hold%0d", w), cand, heldCand[w]);
        end
        prevCv[w] = cv;
    endtask

    // Monitor: compares every DUT output event against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pmValid0) monitorPm(0, pmOut0, pathCnt0);
            if (pmValid2) monitorPm(1, pmOut2, pathCnt2);
            monitorCand(0, bus0.cand_valid, bus0.cand_pm);
            monitorCand(1, bus2.cand_valid, bus2.cand_pm);
        end
    end

    task automatic applyStimulus(int w, logic [23:0] llr, logic frz,
                                 logic [63:0] cand, logic [31:0] pm, logic [2:0] pc);
        logic accepted;
        int   lat;
        int   expLat;
        expLat = frz ? 1 : ((w == 0) ? 2 : 4);
        pushExp(w, frz, cand, pm, pc);
        @(negedge clk);
        driveLlr(w, 1'b1, llr, frz);
        accepted = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (getReady(w)) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accept", accepted, 1);
        if (accepted) begin
            @(posedge clk);
            lat = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (k == 1) driveLlr(w, 1'b0, 24'h0, 1'b0);
                if (frz) checkOutput("frozen_no_cand", getCv(w), 0);
                if (getPv(w)) begin
                    lat = k;
                    break;
                end
            end
            checkOutput("latency", lat, expLat);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] cvPat, pvPat;
        driveLlr(0, 1'b0, 24'h0, 1'b0);
        driveLlr(1, 1'b0, 24'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_pm_out", pmOut0, 32'h00FFFFFF);
        checkOutput("rst_path_cnt", pathCnt0, 1);
        checkOutput("rst_llr_ready", bus0.llr_ready, 1);
        checkOutput("rst_cand_valid", bus0.cand_valid, 0);
        checkOutput("rst_pm_valid", pmValid0, 0);
        checkOutput("rst_cand_pm", bus0.cand_pm, 64'h0);
        checkOutput("rst_pm_out2", pmOut2, 32'h00FFFFFF);

        $display("[TB] info bits, combinational sorter");
        applyStimulus(0, {6'h05, 18'h0}, 1'b0, 64'h0005FFFFFFFFFFFF, 32'h0005FFFF, 3'd2);
        applyStimulus(0, {6'h3D, 6'h02, 12'h0}, 1'b0, 64'h00030507FFFFFFFF, 32'h00030507, 3'd4);

        $display("[TB] frozen bit");
        applyStimulus(0, {6'h3C, 6'h06, 6'h20, 6'h01}, 1'b1, 64'h0, 32'h04032507, 3'd4);
        applyStimulus(0, 24'h0, 1'b0, 64'h0404030325250707, 32'h03030404, 3'd4);

        $display("[TB] start pulse, then saturation");
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("start_pm_out", pmOut0, 32'h00FFFFFF);
        checkOutput("start_path_cnt", pathCnt0, 1);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(0, {4{6'h20}}, 1'b1, 64'h0, {8'(i * 32), 24'hFFFFFF}, 3'd1);
        end
        applyStimulus(0, {4{6'h26}}, 1'b1, 64'h0, 32'hFAFFFFFF, 3'd1);
        applyStimulus(0, {6'h20, 18'h0}, 1'b0, 64'hFAFFFFFFFFFFFFFF, 32'hFAFFFFFF, 3'd2);

        $display("[TB] start aborts a sort");
        expCand0.push_back(64'hFAFBFFFFFFFFFFFF);
        @(negedge clk);
        driveLlr(0, 1'b1, {6'h01, 18'h0}, 1'b0);
        checkOutput("abort_ready", bus0.llr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        driveLlr(0, 1'b0, 24'h0, 1'b0);
        start0 = 1'b1;
        checkOutput("abort_in_sort", bus0.cand_valid, 1);
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("abort_pm_out", pmOut0, 32'h00FFFFFF);
        checkOutput("abort_path_cnt", pathCnt0, 1);
        checkOutput("abort_cand_valid", bus0.cand_valid, 0);
        checkOutput("abort_pm_valid", pmValid0, 0);
        repeat (3) @(negedge clk);

        $display("[TB] start with llr_valid");
        start0 = 1'b1;
        driveLlr(0, 1'b1, {6'h07, 18'h0}, 1'b0);
        #1;
        checkOutput("start_blocks_ready", bus0.llr_ready, 0);
        @(negedge clk);
        start0 = 1'b0;
        driveLlr(0, 1'b0, 24'h0, 1'b0);
        checkOutput("start_no_accept", bus0.cand_valid, 0);
        repeat (2) @(negedge clk);
        applyStimulus(0, {6'h07, 18'h0}, 1'b0, 64'h0007FFFFFFFFFFFF, 32'h0007FFFF, 3'd2);

        $display("[TB] pipelined sorter with held llr_valid");
        pushExp(1, 1'b0, 64'h0005FFFFFFFFFFFF, 32'h0005FFFF, 3'd2);
        pushExp(1, 1'b0, 64'h00030507FFFFFFFF, 32'h00030507, 3'd4);
        cvPat = 8'b01110111;
        pvPat = 8'b10001000;
        @(negedge clk);
        driveLlr(1, 1'b1, {6'h05, 18'h0}, 1'b0);
        checkOutput("slow_ready", bus2.llr_ready, 1);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("slow_cv_k%0d", k), bus2.cand_valid, cvPat[k-1]);
            checkOutput($sformatf("slow_ready_k%0d", k), bus2.llr_ready, pvPat[k-1]);
            checkOutput($sformatf("slow_pv_k%0d", k), pmValid2, pvPat[k-1]);
            if (k == 1) driveLlr(1, 1'b1, {6'h3D, 6'h02, 12'h0}, 1'b0);
            if (k == 5) driveLlr(1, 1'b0, 24'h0, 1'b0);
        end
        repeat (3) @(negedge clk);

        checkOutput("queue_pm0_empty", expPm0.size(), 0);
        checkOutput("queue_pm2_empty", expPm2.size(), 0);
        checkOutput("queue_cand0_empty", expCand0.size(), 0);
        checkOutput("queue_cand2_empty", expCand2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pm_candidate_gen.md
Name: pm_candidate_gen

Overview:
- Path-metric front end of the L=4 SCL list decoder: the writer side of the 4-survivor PM sorter.
- Holds the L sorted path metrics. Per decoded bit it expands them into 2L candidate PMs in the order the sorter requires (m_{2l} <= m_{2l+1}, m_{2l} <= m_{2l+2}).
- Drives the candidates to the sorter and captures the returned L survivors as the new PM set.
- Frozen bits bypass the sorter.

Parameters:
- PM_WIDTH, 8, unsigned path-metric width; must be >= LLR_WIDTH.
- LLR_WIDTH, 6, signed two's-complement LLR width.
- SORT_LAT, 0, sorter pipeline depth in cycles (0 = combinational sorter).
- L, 4, list size; localparam, fixed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  new-codeword pulse; reinitialises PMs.
- llr_valid  in  1  LLR vector valid.
- llr_ready  out  1  block can accept an LLR vector.
- llr_in  in  LLR_WIDTH*L  per-path LLR; path 0 at MSB.
- frozen  in  1  current bit is frozen; qualified by the llr handshake.
- cand_pm  out  PM_WIDTH*2L  candidates {m0..m7}, m0 at MSB; to sorter PM_in.
- cand_valid  out  1  cand_pm is stable and being sorted.
- surv_pm  in  PM_WIDTH*L  sorted survivors {s0..s3}, s0 at MSB; from sorter PM_out.
- pm_out  out  PM_WIDTH*L  current PM registers, path 0 at MSB.
- pm_valid  out  1  one-cycle pulse after each PM update.
- path_cnt  out  3  number of active paths: 1, 2 or 4.

Behaviour:
- Reset (async, rst_n=0):
  - PM0=0; PM1..PM3 = all-ones (inactive, always lose).
  - path_cnt=1; state IDLE; llr_ready=1; cand_valid=0; pm_valid=0; cand_pm=0.
- States:
  - IDLE: llr_ready=1 unless start=1.
  - SORT: llr_ready=0, cand_valid=1.
- Arithmetic, per path l:
  - mag = |llr_l|, zero-extended to PM_WIDTH. -2^(LLR_WIDTH-1) gives 2^(LLR_WIDTH-1), no overflow.
  - Hard decision bit = 1 iff llr_l < 0.
  - All additions saturate at all-ones. An inactive PM (all-ones) plus anything stays all-ones.
- Frozen bit (handshake in IDLE, frozen=1):
  - At the same edge: PM_l <= PM_l + (llr_l<0 ? mag : 0) for all l.
  - path_cnt unchanged; pm_valid=1 the next cycle; stay IDLE; sorter unused.
  - The PM order may change after this update; the next info bit's ordering property relies on it being re-sorted there.
- Info bit (handshake in IDLE, frozen=0):
  - At the handshake edge: cand m_{2l} <= PM_l and m_{2l+1} <= PM_l + mag_l. Go to SORT with counter=0.
  - SORT lasts SORT_LAT+1 cycles; cand_pm is held constant throughout.
  - At the last SORT edge: PM <= surv_pm; path_cnt <= min(2*path_cnt, 4); go to IDLE; pm_valid=1 the next cycle.
  - Latency, handshake to pm_valid: SORT_LAT+2 cycles.
  - The sorter is value-only. Tie order among equal values is whatever the sorter yields; no index is tracked here.
- start (synchronous pulse):
  - Highest priority in any state: PMs and path_cnt are restored to reset values, state goes to IDLE, cand_valid=0.
  - A SORT in progress is aborted and its surv_pm is discarded; no pm_valid is emitted.
  - If start and llr_valid occur in the same cycle: start wins, the LLR is not accepted (llr_ready=0 that cycle), and the sender retries.
- llr_valid held while in SORT: no accept until back in IDLE. llr_in and frozen are sampled only on the handshake edge.
- pm_out always reflects the PM registers; it changes only at update edges.

Test Plan:
- Reset, then info bit with llr=(+5,x,x,x), SORT_LAT=0:
  - cand_pm = {0,5,FF,FF,FF,FF,FF,FF}.
  - Loopback sorter → pm_out={0,5,FF,FF}; path_cnt=2; pm_valid 2 cycles after handshake.
- From PM={0,5,FF,FF}, info bit with llr=(-3,+2,0,0):
  - cand={0,3,5,7,FF,FF,FF,FF}; pm_out={0,3,5,7}; path_cnt=4.
  - A third info bit keeps path_cnt=4.
- Frozen bit from PM={0,3,5,7} with llr=(-4,+6,-32,+1):
  - pm_out={4,3,37,7} next edge; cand_valid never asserts.
- Saturation: PM={FA,...}, info bit with llr=-32 → candidate FF, not wrap-around 1A.
- SORT_LAT=2:
  - cand_valid high exactly 3 cycles and llr_ready low throughout.
  - A held llr_valid is accepted only after return to IDLE.
  - surv_pm is sampled on the 3rd SORT edge.
- start asserted during SORT cycle 1:
  - Next cycle: IDLE, PM={0,FF,FF,FF}, path_cnt=1, no pm_valid.
  - start together with llr_valid in IDLE → LLR not accepted.
